// File: rtl/drive_cmd_sched.sv
// Command scheduler for the left/right motor drivers: frame parsing, emergency-stop latch,
// link watchdog and a per-side direction FSM that coasts for DEADTIME ticks between drives.
module drive_cmd_sched #(
  parameter int DEADTIME = 4,
  parameter int TIMEOUT  = 250,
  parameter int WDW      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tick,
  output logic [1:0] lcmd,
  output logic [1:0] rcmd,
  output logic       link_ok,
  output logic       estop
);

  localparam int DCW = (DEADTIME < 2) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [DCW-1:0] DT_LAST = DCW'(DEADTIME - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  logic           estop_q, estop_d;
  logic           link_ok_q, link_ok_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [1:0]     req_q [2];
  logic [1:0]     req_d [2];
  state_t         st_q [2];
  state_t         st_d [2];
  logic [1:0]     dir_q [2];
  logic [1:0]     dir_d [2];
  logic [1:0]     out_q [2];
  logic [1:0]     out_d [2];
  logic [DCW-1:0] dcnt_q [2];
  logic [DCW-1:0] dcnt_d [2];
  logic           drive_ok_s;

  // The reserved 11 command is never stored, so the FSM only ever sees stop/fwd/rev.
  function automatic logic [1:0] norm_cmd(input logic [1:0] c);
    return (c == 2'b11) ? 2'b00 : c;
  endfunction

  assign drive_ok_s = rx_valid && (rx_data[7:6] == 2'b00) && !estop_q;

  // Frame decode, estop latch and link watchdog; an accepted drive frame beats a tick.
  always_comb begin
    estop_d   = estop_q;
    link_ok_d = link_ok_q;
    wd_d      = wd_q;
    req_d[0]  = req_q[0];
    req_d[1]  = req_q[1];
    if (drive_ok_s) begin
      req_d[0]  = norm_cmd(rx_data[5:4]);
      req_d[1]  = norm_cmd(rx_data[3:2]);
      wd_d      = '0;
      link_ok_d = 1'b1;
    end else if (link_ok_q && tick) begin
      if (wd_q == WD_LAST) begin
        link_ok_d = 1'b0;
        wd_d      = '0;
        req_d[0]  = 2'b00;
        req_d[1]  = 2'b00;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end else begin
      wd_d = wd_q;
    end
    if (rx_valid) begin
      case (rx_data[7:6])
        2'b11: begin
          estop_d  = 1'b1;
          req_d[0] = 2'b00;
          req_d[1] = 2'b00;
        end
        2'b01:   estop_d = 1'b0;
        default: estop_d = estop_q;
      endcase
    end else begin
      estop_d = estop_q;
    end
  end

  // Per-side direction FSM; DEAD always counts out the full dead-time before re-driving.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      st_d[s]   = st_q[s];
      dir_d[s]  = dir_q[s];
      out_d[s]  = 2'b00;
      dcnt_d[s] = dcnt_q[s];
      case (st_q[s])
        ST_IDLE: begin
          if (req_q[s] != 2'b00) begin
            st_d[s]  = ST_RUN;
            dir_d[s] = req_q[s];
            out_d[s] = req_q[s];
          end else begin
            out_d[s] = 2'b00;
          end
        end
        ST_RUN: begin
          if (req_q[s] != dir_q[s]) begin
            st_d[s]   = ST_DEAD;
            out_d[s]  = 2'b00;
            dcnt_d[s] = '0;
          end else begin
            out_d[s] = dir_q[s];
          end
        end
        ST_DEAD: begin
          if (tick) begin
            if (dcnt_q[s] == DT_LAST) begin
              dcnt_d[s] = '0;
              if (req_q[s] == 2'b00) begin
                st_d[s] = ST_IDLE;
              end else begin
                st_d[s]  = ST_RUN;
                dir_d[s] = req_q[s];
                out_d[s] = req_q[s];
              end
            end else begin
              dcnt_d[s] = dcnt_q[s] + 1'b1;
            end
          end else begin
            dcnt_d[s] = dcnt_q[s];
          end
        end
        default: begin
          st_d[s]   = ST_IDLE;
          dir_d[s]  = 2'b00;
          out_d[s]  = 2'b00;
          dcnt_d[s] = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estop_q   <= 1'b0;
      link_ok_q <= 1'b0;
      wd_q      <= '0;
      for (int s = 0; s < 2; s++) begin
        req_q[s]  <= 2'b00;
        st_q[s]   <= ST_IDLE;
        dir_q[s]  <= 2'b00;
        out_q[s]  <= 2'b00;
        dcnt_q[s] <= '0;
      end
    end else begin
      estop_q   <= estop_d;
      link_ok_q <= link_ok_d;
      wd_q      <= wd_d;
      for (int s = 0; s < 2; s++) begin
        req_q[s]  <= req_d[s];
        st_q[s]   <= st_d[s];
        dir_q[s]  <= dir_d[s];
        out_q[s]  <= out_d[s];
        dcnt_q[s] <= dcnt_d[s];
      end
    end
  end

  assign lcmd    = out_q[0];
  assign rcmd    = out_q[1];
  assign link_ok = link_ok_q;
  assign estop   = estop_q;

endmodule

// File: tb/tb_drive_cmd_sched.sv
// Bench for drive_cmd_sched: vector tables plus hand-written watchdog/dead-time sequences,
// with expected outputs queued at drive time and checked one edge later.
module tb_drive_cmd_sched;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tick;
  logic [1:0] lcmd;
  logic [1:0] rcmd;
  logic       link_ok;
  logic       estop;

  int total;
  int bad;

  drive_cmd_sched #(.DEADTIME(4), .TIMEOUT(250), .WDW(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tick     (tick),
    .lcmd     (lcmd),
    .rcmd     (rcmd),
    .link_ok  (link_ok),
    .estop    (estop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       t;
    logic [1:0] el;
    logic [1:0] er;
    logic       lk;
    logic       es;
  } vec_t;

  typedef struct {
    logic [1:0] l;
    logic [1:0] r;
    logic       lk;
    logic       es;
    string      nm;
  } exp_t;

  exp_t sbq[$];

  // One clock: drive on the falling edge, expect the outputs right after the next rising edge.
  task automatic apply(input logic v, input logic [7:0] d, input logic t,
                       input logic [1:0] el, input logic [1:0] er,
                       input logic lk, input logic es, input string nm);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    tick     = t;
    e.l = el; e.r = er; e.lk = lk; e.es = es; e.nm = nm;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    total++;
    if (lcmd !== got.l || rcmd !== got.r || link_ok !== got.lk || estop !== got.es) begin
      bad++;
      $display("FAIL %s: got l=%b r=%b link=%b estop=%b, want l=%b r=%b link=%b estop=%b",
               got.nm, lcmd, rcmd, link_ok, estop, got.l, got.r, got.lk, got.es);
    end
  endtask

  vec_t tab_a [12];
  vec_t tab_b [21];

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick     = 1'b0;

    // forward from idle, then a left reversal through the dead-time
    tab_a[0]  = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tab_a[1]  = '{1'b1, 8'h14, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tab_a[2]  = '{1'b0, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0};
    tab_a[3]  = '{1'b1, 8'h24, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0};
    tab_a[4]  = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0};
    tab_a[5]  = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0};
    tab_a[6]  = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0};
    tab_a[7]  = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0};
    tab_a[8]  = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0};
    tab_a[9]  = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0};
    tab_a[10] = '{1'b0, 8'h00, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0};
    tab_a[11] = '{1'b0, 8'h00, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0};

    // estop set/ignore/clear, reserved frame, 11 requests acting as stop
    tab_b[0]  = '{1'b1, 8'h14, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tab_b[1]  = '{1'b0, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0};
    tab_b[2]  = '{1'b1, 8'hC0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b1};
    tab_b[3]  = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    tab_b[4]  = '{1'b1, 8'h14, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    tab_b[5]  = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1};
    tab_b[6]  = '{1'b1, 8'h14, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1};
    tab_b[7]  = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1};
    tab_b[8]  = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1};
    tab_b[9]  = '{1'b1, 8'h40, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tab_b[10] = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tab_b[11] = '{1'b1, 8'h80, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tab_b[12] = '{1'b1, 8'h14, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tab_b[13] = '{1'b0, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0};
    tab_b[14] = '{1'b1, 8'h3C, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0};
    tab_b[15] = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tab_b[16] = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    tab_b[17] = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    tab_b[18] = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    tab_b[19] = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    tab_b[20] = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};

    // reset held with random traffic
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 8'($urandom), 1'($urandom), 2'b00, 2'b00, 1'b0, 1'b0, "reset_hold");
    end
    apply(1'b1, 8'hC0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "reset_estop");
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply(tab_a[i].v, tab_a[i].d, tab_a[i].t, tab_a[i].el, tab_a[i].er,
            tab_a[i].lk, tab_a[i].es, $sformatf("tab_a[%0d]", i));
    end

    // left reverses back to forward, then the link times out on the 250th tick
    apply(1'b1, 8'h14, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0, "wd_frame");
    apply(1'b0, 8'h00, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, "wd_dead");
    for (int i = 1; i <= 250; i++) begin
      apply(1'b0, 8'h00, 1'b1, (i >= 4) ? 2'b01 : 2'b00, 2'b01, (i < 250) ? 1'b1 : 1'b0,
            1'b0, $sformatf("wd_tick%0d", i));
    end
    apply(1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "wd_coast");
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, $sformatf("wd_down%0d", i));
    end

    for (int i = 0; i < 21; i++) begin
      apply(tab_b[i].v, tab_b[i].d, tab_b[i].t, tab_b[i].el, tab_b[i].er,
            tab_b[i].lk, tab_b[i].es, $sformatf("tab_b[%0d]", i));
    end

    // frame coinciding with the 250th tick restarts the watchdog instead of expiring it
    apply(1'b1, 8'h14, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "sim_frame");
    for (int i = 1; i <= 249; i++) begin
      apply(1'b0, 8'h00, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, $sformatf("sim_a%0d", i));
    end
    apply(1'b1, 8'h14, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, "sim_both");
    for (int i = 1; i <= 249; i++) begin
      apply(1'b0, 8'h00, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, $sformatf("sim_b%0d", i));
    end
    apply(1'b0, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, "sim_expire");
    apply(1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "sim_coast");

    // reset in the middle of the dead-time: the next drive applies without waiting
    reset = 1'b0;
    apply(1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "mid_reset");
    reset = 1'b1;
    apply(1'b1, 8'h24, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "post_frame");
    apply(1'b0, 8'h00, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0, "post_drive");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
